// File: rtl/scr1_ahb_tb_status_pkg.sv
// Shared definitions for the AHB test-status / console responder:
// register offsets, STATUS bit positions and the bus FSM states.
package scr1_tb_status_pkg;

  localparam logic [3:0] OFF_TX     = 4'h0;
  localparam logic [3:0] OFF_EXIT   = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_CYCLE  = 4'hC;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam int STATUS_DONE_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_FULL_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // A zero pattern would never produce a ready cycle, so it is read as all-ones.
  function automatic logic [31:0] fix_pattern(input logic [31:0] p);
    return (p == 32'h0) ? 32'hFFFF_FFFF : p;
  endfunction

endpackage

// File: rtl/scr1_ahb_tb_status_fifo.sv
// Console byte FIFO: show-ahead head, simultaneous push/pop allowed even when full.
module scr1_tb_status_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/scr1_ahb_tb_status.sv
// AHB-Lite test-status/console responder with pattern-driven wait states.
// Optional free-running CYCLE register at 0xC: define SCR1_TB_STATUS_CYCLE_EN.
module scr1_ahb_tb_status
  import scr1_tb_status_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] stall_pattern_in,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  output logic        hready,
  output logic [31:0] hrdata,
  output logic        hresp,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        test_done,
  output logic [31:0] test_code
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  logic [3:0]    off_q, off_d;
  logic          write_q, write_d;
  logic [31:0]   stall_q, stall_d;
  logic          done_q, done_d;
  logic [31:0]   code_q, code_d;

  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [7:0]    fifo_head;
  logic          pop, push, accept, complete, tx_block, bad_req;
  logic          unused_htrans;

  assign unused_htrans = htrans[0];

`ifdef SCR1_TB_STATUS_CYCLE_EN
  logic [31:0] cnt_q, cnt_d;
  assign cnt_d = cnt_q + 32'd1;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  // A TX write into a full FIFO may still finish when the drain pops on the same edge.
  assign pop      = ~fifo_empty & tx_ready;
  assign tx_block = write_q & (off_q == OFF_TX) & fifo_full & ~pop;
  assign complete = (state_q == ST_DATA) & stall_q[0] & ~tx_block;
  assign hready   = (state_q == ST_IDLE) | (state_q == ST_ERR2) | complete;
  assign hresp    = (state_q == ST_ERR1) | (state_q == ST_ERR2);
  assign accept   = hsel & htrans[1] & hready;
  assign push     = complete & write_q & (off_q == OFF_TX);

  // Bad transfers are known in the address phase, so they go straight to the error pair.
  always_comb begin
    bad_req = 1'b1;
    if (haddr[31:4] == BASE_ADDR[31:4]) begin
      case (haddr[3:0])
        OFF_TX:     bad_req = 1'b0;
        OFF_EXIT:   bad_req = (hsize != HSIZE_WORD);
        OFF_STATUS: bad_req = hwrite | (hsize != HSIZE_WORD);
`ifdef SCR1_TB_STATUS_CYCLE_EN
        OFF_CYCLE:  bad_req = hwrite | (hsize != HSIZE_WORD);
`endif
        default:    bad_req = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    write_d = write_q;
    stall_d = stall_q;
    done_d  = done_q;
    code_d  = code_q;
    if (state_q == ST_DATA) stall_d = {stall_q[0], stall_q[31:1]};
    case (state_q)
      ST_DATA: if (complete) state_d = ST_IDLE;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = bad_req ? ST_ERR1 : ST_DATA;
      off_d   = haddr[3:0];
      write_d = hwrite;
      stall_d = fix_pattern(stall_pattern_in);
    end
    if (complete && write_q && (off_q == OFF_EXIT)) begin
      done_d = 1'b1;
      code_d = hwdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      off_q   <= '0;
      write_q <= 1'b0;
      stall_q <= fix_pattern(stall_pattern_in);
      done_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      write_q <= write_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    hrdata = '0;
    if (complete && !write_q) begin
      case (off_q)
        OFF_TX:   hrdata = {{(32-LW){1'b0}}, fifo_level};
        OFF_EXIT: hrdata = code_q;
        OFF_STATUS: begin
          hrdata[STATUS_FULL_BIT]  = fifo_full;
          hrdata[STATUS_EMPTY_BIT] = fifo_empty;
          hrdata[STATUS_DONE_BIT]  = done_q;
        end
`ifdef SCR1_TB_STATUS_CYCLE_EN
        OFF_CYCLE: hrdata = cnt_q;
`endif
        default:  hrdata = '0;
      endcase
    end
  end

  scr1_tb_status_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (hwdata[7:0]),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign tx_valid  = ~fifo_empty;
  assign tx_data   = fifo_head;
  assign test_done = done_q;
  assign test_code = code_q;

endmodule

// File: tb/tb_scr1_ahb_tb_status.sv
// Directed bench for scr1_ahb_tb_status: inputs change 1ns after posedge, outputs sampled on negedge.
module tb_scr1_ahb_tb_status;
  localparam logic [31:0] BASE = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] stall_pattern_in = 32'hFFFF_FFFF;
  logic        hsel = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] hwdata = '0;
  logic        hready, hresp;
  logic [31:0] hrdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        test_done;
  logic [31:0] test_code;

  int tests = 0;
  int fails = 0;
  logic [7:0]  popped[$];
  logic [31:0] rd;
  int          w, e, lk;

  always #5 clk = ~clk;

  scr1_ahb_tb_status dut (
    .clk(clk), .rst_n(rst_n), .stall_pattern_in(stall_pattern_in),
    .hsel(hsel), .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .hwdata(hwdata), .hready(hready), .hrdata(hrdata), .hresp(hresp),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .test_done(test_done), .test_code(test_code)
  );

  always @(negedge clk) if (tx_valid && tx_ready) popped.push_back(tx_data);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // One non-pipelined transfer; reports wait cycles, hresp cycles and hrdata leaks during waits.
  task automatic bus_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output int waits, output int errs, output int leak);
    rdata = '0; waits = 0; errs = 0; leak = 0;
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wdata;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (hresp) errs++;
      if (hready) begin
        rdata = hrdata;
        return;
      end
      if (hrdata !== 32'h0) leak++;
      waits++;
    end
  endtask

  task automatic set_tx_ready(input logic v);
    @(posedge clk); #1;
    tx_ready = v;
  endtask

  task automatic do_reset(input logic [31:0] pat);
    @(posedge clk); #1;
    rst_n = 1'b0; stall_pattern_in = pat;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    stall_pattern_in = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    tests++; if (hready !== 1'b1)    begin fails++; $display("FAIL reset_hready: got %b expected 1", hready); end
    tests++; if (hresp !== 1'b0)     begin fails++; $display("FAIL reset_hresp: got %b expected 0", hresp); end
    tests++; if (hrdata !== 32'h0)   begin fails++; $display("FAIL reset_hrdata: got %h expected 0", hrdata); end
    tests++; if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin fails++; $display("FAIL reset_tx: got valid=%b data=%h expected 0/00", tx_valid, tx_data); end
    tests++; if (test_done !== 1'b0 || test_code !== 32'h0) begin fails++; $display("FAIL reset_test: got done=%b code=%h expected 0/0", test_done, test_code); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_tx_single();
    int vcnt;
    vcnt = 0;
    set_tx_ready(1'b1);
    popped.delete();
    bus_xfer(BASE + 32'h0, 1'b1, 3'b000, 32'h0000_0041, rd, w, e, lk);
    tests++; if (w !== 0 || e !== 0) begin fails++; $display("FAIL tx_single_resp: got waits=%0d errs=%0d expected 0/0", w, e); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        vcnt++;
        tests++; if (tx_data !== 8'h41) begin fails++; $display("FAIL tx_single_data: got %h expected 41", tx_data); end
      end
    end
    tests++; if (vcnt !== 1) begin fails++; $display("FAIL tx_single_valid_cycles: got %0d expected 1", vcnt); end
    tests++; if (popped.size() !== 1) begin fails++; $display("FAIL tx_single_pops: got %0d expected 1", popped.size()); end
    set_tx_ready(1'b0);
  endtask

  task automatic test_stall();
    do_reset(32'hFFFF_FFFC);
    bus_xfer(BASE + 32'h8, 1'b0, 3'b010, 32'h0, rd, w, e, lk);
    tests++; if (w !== 2)        begin fails++; $display("FAIL stall2_waits: got %0d expected 2", w); end
    tests++; if (rd !== 32'h2)   begin fails++; $display("FAIL stall2_status: got %h expected 00000002", rd); end
    tests++; if (lk !== 0 || e !== 0) begin fails++; $display("FAIL stall2_clean: got leak=%0d errs=%0d expected 0/0", lk, e); end
    stall_pattern_in = 32'hFFFF_FFFE;
    bus_xfer(BASE + 32'h8, 1'b0, 3'b010, 32'h0, rd, w, e, lk);
    tests++; if (w !== 1) begin fails++; $display("FAIL stall1_waits: got %0d expected 1", w); end
    stall_pattern_in = 32'h0;
    bus_xfer(BASE + 32'h4, 1'b0, 3'b010, 32'h0, rd, w, e, lk);
    tests++; if (w !== 0 || rd !== 32'h0) begin fails++; $display("FAIL stall0_as_ones: got waits=%0d data=%h expected 0/0", w, rd); end
    stall_pattern_in = 32'hFFFF_FFFF;
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp_q[$];
    set_tx_ready(1'b0);
    for (int i = 0; i < 8; i++) begin
      bus_xfer(BASE, 1'b1, 3'b000, 32'h10 + i, rd, w, e, lk);
      exp_q.push_back(8'(8'h10 + i));
      tests++; if (w !== 0) begin fails++; $display("FAIL fill_waits[%0d]: got %0d expected 0", i, w); end
    end
    bus_xfer(BASE + 32'h8, 1'b0, 3'b010, 32'h0, rd, w, e, lk);
    tests++; if (rd !== 32'h4) begin fails++; $display("FAIL full_status: got %h expected 00000004", rd); end
    popped.delete();
    fork
      bus_xfer(BASE, 1'b1, 3'b010, 32'hAB_CD_EF18, rd, w, e, lk);
      begin
        repeat (6) @(posedge clk);
        #1 tx_ready = 1'b1;
        @(posedge clk);
        #1 tx_ready = 1'b0;
      end
    join
    exp_q.push_back(8'h18);
    tests++; if (w !== 4 || e !== 0) begin fails++; $display("FAIL full_write_wait: got waits=%0d errs=%0d expected 4/0", w, e); end
    bus_xfer(BASE, 1'b0, 3'b010, 32'h0, rd, w, e, lk);
    tests++; if (rd !== 32'h8) begin fails++; $display("FAIL full_level: got %h expected 00000008", rd); end
    set_tx_ready(1'b1);
    repeat (12) @(negedge clk);
    set_tx_ready(1'b0);
    tests++; if (popped !== exp_q) begin fails++; $display("FAIL fifo_order: got %p expected %p", popped, exp_q); end
    bus_xfer(BASE + 32'h8, 1'b0, 3'b010, 32'h0, rd, w, e, lk);
    tests++; if (rd !== 32'h2) begin fails++; $display("FAIL drained_status: got %h expected 00000002", rd); end
  endtask

  task automatic test_back_to_back();
    int ok;
    ok = 0;
    set_tx_ready(1'b0);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = BASE; hwrite = 1'b1; hsize = 3'b000;
    @(posedge clk); #1;
    hwdata = 32'h61;
    @(negedge clk); if (hready === 1'b1) ok++;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h62;
    @(negedge clk); if (hready === 1'b1) ok++;
    tests++; if (ok !== 2) begin fails++; $display("FAIL b2b_ready: got %0d ready phases expected 2", ok); end
    bus_xfer(BASE, 1'b0, 3'b010, 32'h0, rd, w, e, lk);
    tests++; if (rd !== 32'h2) begin fails++; $display("FAIL b2b_level: got %h expected 00000002", rd); end
    popped.delete();
    set_tx_ready(1'b1);
    repeat (4) @(negedge clk);
    set_tx_ready(1'b0);
    tests++; if (popped.size() !== 2 || popped[0] !== 8'h61 || popped[1] !== 8'h62) begin fails++; $display("FAIL b2b_order: got %p expected 61,62", popped); end
  endtask

  task automatic test_exit();
    bus_xfer(BASE + 32'h4, 1'b1, 3'b010, 32'h0, rd, w, e, lk);
    tests++; if (test_done !== 1'b0) begin fails++; $display("FAIL exit_early: got done=%b expected 0 during completion", test_done); end
    @(negedge clk);
    tests++; if (test_done !== 1'b1 || test_code !== 32'h0) begin fails++; $display("FAIL exit0: got done=%b code=%h expected 1/0", test_done, test_code); end
    bus_xfer(BASE + 32'h4, 1'b1, 3'b010, 32'h5, rd, w, e, lk);
    @(negedge clk);
    tests++; if (test_done !== 1'b1 || test_code !== 32'h5) begin fails++; $display("FAIL exit5: got done=%b code=%h expected 1/5", test_done, test_code); end
    bus_xfer(BASE + 32'h4, 1'b0, 3'b010, 32'h0, rd, w, e, lk);
    tests++; if (rd !== 32'h5) begin fails++; $display("FAIL exit_read: got %h expected 00000005", rd); end
    bus_xfer(BASE + 32'h8, 1'b0, 3'b010, 32'h0, rd, w, e, lk);
    tests++; if (rd !== 32'h3) begin fails++; $display("FAIL exit_status: got %h expected 00000003", rd); end
  endtask

  task automatic test_errors();
    bus_xfer(BASE + 32'h8, 1'b1, 3'b010, 32'hFFFF_FFFF, rd, w, e, lk);
    tests++; if (w !== 1 || e !== 2) begin fails++; $display("FAIL err_status_write: got waits=%0d errs=%0d expected 1/2", w, e); end
    bus_xfer(BASE + 32'h4, 1'b0, 3'b000, 32'h0, rd, w, e, lk);
    tests++; if (w !== 1 || e !== 2) begin fails++; $display("FAIL err_byte_read: got waits=%0d errs=%0d expected 1/2", w, e); end
    bus_xfer(BASE + 32'h4, 1'b1, 3'b001, 32'h77, rd, w, e, lk);
    tests++; if (w !== 1 || e !== 2) begin fails++; $display("FAIL err_half_exit: got waits=%0d errs=%0d expected 1/2", w, e); end
    bus_xfer(BASE + 32'h10, 1'b1, 3'b000, 32'h55, rd, w, e, lk);
    tests++; if (w !== 1 || e !== 2) begin fails++; $display("FAIL err_region: got waits=%0d errs=%0d expected 1/2", w, e); end
    @(negedge clk);
    tests++; if (test_done !== 1'b1 || test_code !== 32'h5) begin fails++; $display("FAIL err_side_effect: got done=%b code=%h expected 1/5", test_done, test_code); end
    bus_xfer(BASE + 32'h8, 1'b0, 3'b010, 32'h0, rd, w, e, lk);
    tests++; if (rd !== 32'h3 || e !== 0) begin fails++; $display("FAIL err_status_after: got %h errs=%0d expected 00000003/0", rd, e); end
  endtask

  task automatic test_cycle();
`ifdef SCR1_TB_STATUS_CYCLE_EN
    logic [31:0] first;
    bus_xfer(BASE + 32'hC, 1'b0, 3'b010, 32'h0, rd, w, e, lk);
    first = rd;
    repeat (10) @(negedge clk);
    bus_xfer(BASE + 32'hC, 1'b0, 3'b010, 32'h0, rd, w, e, lk);
    tests++; if (rd - first !== 32'd12 || e !== 0) begin fails++; $display("FAIL cycle_delta: got %0d errs=%0d expected 12/0", rd - first, e); end
`else
    bus_xfer(BASE + 32'hC, 1'b0, 3'b010, 32'h0, rd, w, e, lk);
    tests++; if (w !== 1 || e !== 2) begin fails++; $display("FAIL cycle_absent: got waits=%0d errs=%0d expected 1/2", w, e); end
`endif
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_stall();
    test_fifo_full();
    test_back_to_back();
    test_exit();
    test_errors();
    test_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
